// File: rtl/pst_pkg.sv
// Shared constants and types for the phase-target stimulus encoder and its
// neighbours (winner mapping, replay controller).
package pst_pkg;

  localparam int THRESHOLD_DEF = 200;
  localparam int CYCLE_LEN     = 256;
  localparam int NCH_DEF       = 4;

  // Pair-index phase map: the phase at which each channel pair is signalled.
  localparam logic [7:0] PH_AB = 8'd0;
  localparam logic [7:0] PH_AC = 8'd43;
  localparam logic [7:0] PH_AD = 8'd85;
  localparam logic [7:0] PH_BC = 8'd128;
  localparam logic [7:0] PH_BD = 8'd170;
  localparam logic [7:0] PH_CD = 8'd213;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_STAGE = 2'd2
  } pst_state_e;

  // A target phase of 0 is encoded as phase 1 (maximum current).
  function automatic logic [7:0] eff_phase(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/pst_ceil_div.sv
// Sequential 9-bit by 8-bit restoring divider: one load clock, then nine
// iterations; o_done pulses for the clock after the last iteration.
module pst_ceil_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [8:0] i_num,
  input  logic [7:0] i_den,
  output logic       o_done,
  output logic [7:0] o_quo
);

  logic [8:0] r_quo;
  logic [7:0] r_rem;
  logic [7:0] r_den;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_done;

  logic [8:0] w_shift;
  logic       w_ge;
  logic [7:0] w_sub;

  // Remainder stays below the divisor, so the shifted value fits 9 bits and
  // a successful subtraction always fits 8.
  assign w_shift = {r_rem, r_quo[8]};
  assign w_ge    = (w_shift >= {1'b0, r_den});
  assign w_sub   = w_shift[7:0] - r_den;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo  <= i_num;
        r_rem  <= '0;
        r_den  <= i_den;
        r_cnt  <= 4'd9;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (w_ge) begin
          r_rem <= w_sub;
          r_quo <= {r_quo[7:0], 1'b1};
        end else begin
          r_rem <= w_shift[7:0];
          r_quo <= {r_quo[7:0], 1'b0};
        end
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quo  = r_quo[7:0];

endmodule

// File: rtl/pst_stim_encoder.sv
// Phase-target stimulus encoder: turns four target firing phases into constant
// neuron currents and applies them on gamma cycle_start for a held number of cycles.
module pst_stim_encoder
  import pst_pkg::*;
#(
  parameter int THRESHOLD = THRESHOLD_DEF,
  parameter int NCH       = NCH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cycle_start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_phase,
  input  logic [3:0]  req_en,
  input  logic [7:0]  req_hold,
  output logic [7:0]  cur0,
  output logic [7:0]  cur1,
  output logic [7:0]  cur2,
  output logic [7:0]  cur3,
  output logic        active,
  output logic        applied,
  output logic [7:0]  hold_left,
  output logic [1:0]  dbg_state,
  output logic        dbg_staged_full
);

  localparam logic [8:0] THR9 = 9'(THRESHOLD);

  // Handshake: a request transfers on the clock edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE with nothing staged.

  pst_state_e r_state;
  logic [31:0] r_phase;
  logic [3:0]  r_en;
  logic [7:0]  r_hold;
  logic [1:0]  r_ch;
  logic [3:0]  r_cnt;
  logic [1:0]  r_div_ch;
  logic        r_staged;
  logic [7:0]  r_stage [NCH];
  logic [7:0]  r_cur   [NCH];
  logic [7:0]  r_hold_left;
  logic        r_active;
  logic        r_applied;

  logic [7:0]  w_t;
  logic [8:0]  w_num;
  logic        w_start;
  logic        w_done;
  logic [7:0]  w_quo;
  logic [7:0]  w_hold_eff;
  logic        w_last_ch;

  assign w_t        = r_phase[{r_ch, 3'b000} +: 8];
  assign w_num      = THR9 + {1'b0, eff_phase(w_t)} - 9'd1;
  assign w_start    = (r_state == ST_DIV) && (r_cnt == 4'd0) && r_en[r_ch];
  assign w_hold_eff = (r_hold == 8'd0) ? 8'd1 : r_hold;
  assign w_last_ch  = (r_ch == 2'(NCH - 1));

  assign req_ready  = (r_state == ST_IDLE) && !r_staged && !rst;

  pst_ceil_div u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_num   (w_num),
    .i_den   (eff_phase(w_t)),
    .o_done  (w_done),
    .o_quo   (w_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_en        <= '0;
      r_hold      <= '0;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_div_ch    <= '0;
      r_staged    <= 1'b0;
      r_hold_left <= '0;
      r_active    <= 1'b0;
      r_applied   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_stage[c] <= '0;
        r_cur[c]   <= '0;
      end
    end else begin
      r_applied <= 1'b0;

      // The quotient settles one clock after the last iteration; it lands
      // while the sequencer is already on the next channel or in STAGE.
      if (w_done) r_stage[r_div_ch] <= w_quo;

      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_phase <= req_phase;
            r_en    <= req_en;
            r_hold  <= req_hold;
            r_ch    <= '0;
            r_cnt   <= '0;
            for (int c = 0; c < NCH; c++) r_stage[c] <= '0;
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (r_cnt == 4'd0 && r_en[r_ch]) begin
            r_cnt    <= 4'd1;
            r_div_ch <= r_ch;
          end else if (r_cnt == 4'd0 || r_cnt == 4'd9) begin
            r_cnt <= '0;
            if (w_last_ch) r_state <= ST_STAGE;
            else           r_ch    <= r_ch + 2'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_STAGE: begin
          r_staged <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // A staged request only takes over when the running hold is on its last cycle.
      if (cycle_start) begin
        if (r_staged && r_hold_left <= 8'd1) begin
          r_cur       <= r_stage;
          r_hold_left <= w_hold_eff;
          r_active    <= 1'b1;
          r_applied   <= 1'b1;
          r_staged    <= 1'b0;
        end else if (r_hold_left == 8'd1) begin
          for (int c = 0; c < NCH; c++) r_cur[c] <= '0;
          r_hold_left <= '0;
          r_active    <= 1'b0;
        end else if (r_hold_left > 8'd1) begin
          r_hold_left <= r_hold_left - 8'd1;
        end
      end
    end
  end

  assign cur0            = r_cur[0];
  assign cur1            = r_cur[1];
  assign cur2            = r_cur[2];
  assign cur3            = r_cur[3];
  assign active          = r_active;
  assign applied         = r_applied;
  assign hold_left       = r_hold_left;
  assign dbg_state       = r_state;
  assign dbg_staged_full = r_staged;

endmodule

// File: tb/tb_pst_stim_encoder.sv
// Directed bench for pst_stim_encoder: encode values, staging latency, hold
// sequencing, apply alignment and asynchronous reset.
module tb_pst_stim_encoder;
  import pst_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cycle_start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_phase = '0;
  logic [3:0]  req_en = '0;
  logic [7:0]  req_hold = '0;
  logic [7:0]  cur0, cur1, cur2, cur3;
  logic        active, applied;
  logic [7:0]  hold_left;
  logic [1:0]  dbg_state;
  logic        dbg_staged_full;
  logic [31:0] cur_all;

  int n_cmp = 0;
  int n_fail = 0;
  int n_applied = 0;
  int gcnt = 0;

  assign cur_all = {cur3, cur2, cur1, cur0};

  pst_stim_encoder #(.THRESHOLD(200), .NCH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cycle_start     (cycle_start),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_phase       (req_phase),
    .req_en          (req_en),
    .req_hold        (req_hold),
    .cur0            (cur0),
    .cur1            (cur1),
    .cur2            (cur2),
    .cur3            (cur3),
    .active          (active),
    .applied         (applied),
    .hold_left       (hold_left),
    .dbg_state       (dbg_state),
    .dbg_staged_full (dbg_staged_full)
  );

  // Clock and gamma oscillator: cycle_start is high for one clock every 256.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    gcnt = (gcnt == CYCLE_LEN - 1) ? 0 : gcnt + 1;
    cycle_start = (gcnt == 0);
  end

  always @(posedge clk) if (applied) n_applied++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after the next cycle_start edge.
  task automatic wait_cs();
    int n = 0;
    while (cycle_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (cycle_start !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_cs: cycle_start not seen within %0d clocks", n);
    end
    @(negedge clk);
  endtask

  // Presents a request for one clock; returns at the negedge after the accept edge.
  task automatic send_req(input logic [31:0] ph, input logic [3:0] en, input logic [7:0] hold);
    req_phase = ph;
    req_en    = en;
    req_hold  = hold;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++; if (cur_all !== 32'd0) begin n_fail++; $display("FAIL reset_cur: got %h expected 0", cur_all); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    n_cmp++; if ({active, applied, hold_left} !== 10'd0) begin n_fail++; $display("FAIL reset_flags: got %h expected 0", {active, applied, hold_left}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_basic();
    wait_cs();
    tick(5);
    send_req({8'd0, 8'd255, 8'd7, 8'd10}, 4'b1111, 8'd1);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_fall: got %b expected 0", req_ready); end
    n_cmp++; if (dbg_state !== ST_DIV) begin n_fail++; $display("FAIL basic_state_div: got %0d expected %0d", dbg_state, ST_DIV); end
    tick(40);
    n_cmp++; if (dbg_staged_full !== 1'b0) begin n_fail++; $display("FAIL basic_staged_early: got %b expected 0 at +40", dbg_staged_full); end
    tick(1);
    n_cmp++; if (dbg_staged_full !== 1'b1) begin n_fail++; $display("FAIL basic_staged_41: got %b expected 1 at +41", dbg_staged_full); end
    wait_cs();
    n_cmp++; if (cur_all !== {8'd200, 8'd1, 8'd29, 8'd20}) begin n_fail++; $display("FAIL basic_cur: got %h expected %h", cur_all, {8'd200, 8'd1, 8'd29, 8'd20}); end
    n_cmp++; if ({applied, active} !== 2'b11) begin n_fail++; $display("FAIL basic_applied_active: got %b expected 11", {applied, active}); end
    n_cmp++; if (hold_left !== 8'd1) begin n_fail++; $display("FAIL basic_hold_left: got %0d expected 1", hold_left); end
    tick(1);
    n_cmp++; if (applied !== 1'b0) begin n_fail++; $display("FAIL basic_applied_pulse: got %b expected 0", applied); end
    wait_cs();
    n_cmp++; if ({cur_all, active, hold_left} !== 41'd0) begin n_fail++; $display("FAIL basic_expire: got cur %h active %b hold %0d expected all 0", cur_all, active, hold_left); end
  endtask

  task automatic test_disabled();
    wait_cs();
    tick(5);
    send_req({8'd50, 8'd50, 8'd50, 8'd50}, 4'b0101, 8'd1);
    tick(22);
    n_cmp++; if (dbg_staged_full !== 1'b0) begin n_fail++; $display("FAIL dis_staged_early: got %b expected 0 at +22", dbg_staged_full); end
    tick(1);
    n_cmp++; if (dbg_staged_full !== 1'b1) begin n_fail++; $display("FAIL dis_staged_23: got %b expected 1 at +23", dbg_staged_full); end
    wait_cs();
    n_cmp++; if (cur_all !== {8'd0, 8'd4, 8'd0, 8'd4}) begin n_fail++; $display("FAIL dis_cur: got %h expected %h", cur_all, {8'd0, 8'd4, 8'd0, 8'd4}); end
    wait_cs();
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL dis_expire: got active %b expected 0", active); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_applied;
    wait_cs();
    tick(5);
    send_req({8'd40, 8'd30, 8'd20, 8'd10}, 4'b1111, 8'd3);
    wait_cs();
    n_cmp++; if (cur_all !== {8'd5, 8'd7, 8'd10, 8'd20} || hold_left !== 8'd3) begin n_fail++; $display("FAIL b2b_a_apply: got cur %h hold %0d expected %h hold 3", cur_all, hold_left, {8'd5, 8'd7, 8'd10, 8'd20}); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_during_a: got %b expected 1", req_ready); end
    send_req({8'd25, 8'd200, 8'd150, 8'd100}, 4'b1111, 8'd2);
    tick(42);
    n_cmp++; if ({req_ready, dbg_staged_full} !== 2'b01) begin n_fail++; $display("FAIL b2b_b_staged: got ready/staged %b expected 01", {req_ready, dbg_staged_full}); end
    wait_cs();
    n_cmp++; if (hold_left !== 8'd2 || applied !== 1'b0 || cur0 !== 8'd20) begin n_fail++; $display("FAIL b2b_a_cycle2: got hold %0d applied %b cur0 %0d expected 2 0 20", hold_left, applied, cur0); end
    wait_cs();
    n_cmp++; if (hold_left !== 8'd1 || cur0 !== 8'd20) begin n_fail++; $display("FAIL b2b_a_cycle3: got hold %0d cur0 %0d expected 1 20", hold_left, cur0); end
    wait_cs();
    n_cmp++; if (cur_all !== {8'd8, 8'd1, 8'd2, 8'd2}) begin n_fail++; $display("FAIL b2b_b_apply: got %h expected %h", cur_all, {8'd8, 8'd1, 8'd2, 8'd2}); end
    n_cmp++; if ({applied, active, hold_left} !== {2'b11, 8'd2}) begin n_fail++; $display("FAIL b2b_b_flags: got applied %b active %b hold %0d expected 1 1 2", applied, active, hold_left); end
    n_cmp++; if ({dbg_staged_full, req_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_b_unstaged: got staged/ready %b expected 01", {dbg_staged_full, req_ready}); end
    wait_cs();
    n_cmp++; if (hold_left !== 8'd1 || cur0 !== 8'd2) begin n_fail++; $display("FAIL b2b_b_cycle2: got hold %0d cur0 %0d expected 1 2", hold_left, cur0); end
    wait_cs();
    n_cmp++; if ({cur_all, active, hold_left} !== 41'd0) begin n_fail++; $display("FAIL b2b_expire: got cur %h active %b hold %0d expected all 0", cur_all, active, hold_left); end
    n_cmp++; if (n_applied - base !== 2) begin n_fail++; $display("FAIL b2b_applied_count: got %0d expected 2", n_applied - base); end
  endtask

  // Accept 215 clocks after a cycle_start so staging lands exactly on the next one.
  task automatic test_boundary();
    wait_cs();
    tick(214);
    send_req({8'd4, 8'd3, 8'd2, 8'd1}, 4'b1111, 8'd0);
    wait_cs();
    n_cmp++; if ({dbg_staged_full, applied, active} !== 3'b100) begin n_fail++; $display("FAIL bnd_deferred: got staged/applied/active %b expected 100", {dbg_staged_full, applied, active}); end
    n_cmp++; if (cur_all !== 32'd0) begin n_fail++; $display("FAIL bnd_cur_zero: got %h expected 0", cur_all); end
    wait_cs();
    n_cmp++; if (cur_all !== {8'd50, 8'd67, 8'd100, 8'd200}) begin n_fail++; $display("FAIL bnd_cur: got %h expected %h", cur_all, {8'd50, 8'd67, 8'd100, 8'd200}); end
    n_cmp++; if ({applied, hold_left} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL bnd_hold0: got applied %b hold %0d expected 1 1", applied, hold_left); end
    wait_cs();
    n_cmp++; if ({cur_all, active} !== 33'd0) begin n_fail++; $display("FAIL bnd_expire: got cur %h active %b expected 0", cur_all, active); end
  endtask

  task automatic test_reset_mid();
    wait_cs();
    tick(5);
    send_req({8'd0, 8'd255, 8'd7, 8'd10}, 4'b1111, 8'd5);
    wait_cs();
    n_cmp++; if ({active, hold_left} !== {1'b1, 8'd5}) begin n_fail++; $display("FAIL rmid_running: got active %b hold %0d expected 1 5", active, hold_left); end
    send_req({8'd9, 8'd9, 8'd9, 8'd9}, 4'b1111, 8'd1);
    tick(14);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cur_all !== 32'd0) begin n_fail++; $display("FAIL rmid_cur: got %h expected 0", cur_all); end
    n_cmp++; if ({active, applied, hold_left, req_ready} !== 11'd0) begin n_fail++; $display("FAIL rmid_flags: got %h expected 0", {active, applied, hold_left, req_ready}); end
    n_cmp++; if ({dbg_state, dbg_staged_full} !== {ST_IDLE, 1'b0}) begin n_fail++; $display("FAIL rmid_state: got %b expected 000", {dbg_state, dbg_staged_full}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", req_ready); end
    wait_cs();
    tick(5);
    send_req({8'd200, 8'd120, 8'd22, 8'd20}, 4'b1111, 8'd1);
    tick(41);
    wait_cs();
    n_cmp++; if (cur_all !== {8'd1, 8'd2, 8'd10, 8'd10}) begin n_fail++; $display("FAIL rmid_reencode: got %h expected %h", cur_all, {8'd1, 8'd2, 8'd10, 8'd10}); end
    n_cmp++; if ({applied, active} !== 2'b11) begin n_fail++; $display("FAIL rmid_reapply: got %b expected 11", {applied, active}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disabled();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pst_stim_encoder.md
# pst_stim_encoder

Phase-target stimulus encoder: the transmit-side counterpart of the phase-neuron front end. It accepts a request of four target firing phases, computes the constant input currents that make zero-leak phase neurons fire at those phases, and drives `cur0..cur3` aligned to gamma `cycle_start` for a programmable number of gamma cycles. It sits between the test/replay controller and the brain's `cur0..cur3` inputs, and supports both directed stimulus and top-down pattern replay.

## Interface
- `THRESHOLD`, 8'd200: firing threshold of the driven neurons; must match the neuron instances; valid range 1..255.
- `NCH`, 4: channel count; fixed at 4 in this version.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cycle_start` in 1: one-clock pulse from the gamma oscillator at phase 0.
- `req_valid` in 1: request present.
- `req_ready` out 1: encoder can accept a request.
- `req_phase` in 32: target phases; ch0 = [7:0] … ch3 = [31:24].
- `req_en` in 4: per-channel enable; a disabled channel drives 0, so its neuron stays silent.
- `req_hold` in 8: number of gamma cycles to apply; 0 is treated as 1.
- `cur0..cur3` out 8 each: currents to the neurons.
- `active` out 1: a stimulus is currently applied.
- `applied` out 1: one-clock pulse when a new stimulus takes effect.
- `hold_left` out 8: gamma cycles remaining, including the current one.

## Operation
- **Encoding:** for each enabled channel with target t, `cur = ceil(THRESHOLD / max(t,1))`, computed as `floor((THRESHOLD + t' − 1) / t')`.
  - Numerator is 9 bits unsigned (max 454).
  - Quotient is at most THRESHOLD, so it fits 8 bits and is never 0 for an enabled channel.
  - t=0 is treated as t=1, giving cur=THRESHOLD.
- **FSM states:**
  - IDLE: accepts a request when `req_valid && req_ready`, latching phase/en/hold. Goes to DIV with ch=0.
  - DIV: per channel, one load clock followed by 9 restoring-divide iterations (10 clocks). A disabled channel takes 1 clock and stores 0. After ch3, go to STAGE.
  - STAGE: sets `staged_full`, then returns to IDLE.
- **Ready:** `req_ready = (state==IDLE) && !staged_full && !rst`. At most one request is being computed and one is staged.
- **Apply:** on a `cycle_start` clock, decision order:
  1. If `staged_full` and (`hold_left ≤ 1`): load the staged currents into `cur*`, set `hold_left = max(req_hold,1)`, set `active=1`, pulse `applied`, clear `staged_full`.
  2. Else if `hold_left == 1`: clear `cur*` to 0, set `hold_left=0`, set `active=0`.
  3. Else if `hold_left > 1`: decrement `hold_left`.
- **No preemption:** a staged request never cuts a running hold short. It takes over seamlessly on the cycle where the hold expires.
- **Reset:**
  - While `rst` is asserted, or mid-operation, the block returns immediately to IDLE with `staged_full=0`.
  - Outputs reset to: `cur*=0`, `active=0`, `applied=0`, `hold_left=0`, `req_ready=0`.
  - `req_ready` is 1 on the first clock after deassertion.

## Timing
- **Acceptance:** on the edge where `req_valid && req_ready`; `req_ready` falls on the next clock.
- **Compute latency:**
  - All channels enabled: 40 clocks DIV + 1 clock STAGE, so `staged_full` is set at acceptance+41.
  - Disabled channels shorten this by 9 clocks each.
- **Apply alignment:** currents change only on a `cycle_start` clock, so the neuron sees a stable current for the whole gamma cycle.
  - If `staged_full` is set on the same edge as a `cycle_start`, the apply waits for the next `cycle_start` (256 clocks later).
- **Pulses:** `applied` is high for exactly the clock after the apply edge, coincident with the new `cur*`.
- **Compute vs gamma cycle:** compute (≤41 clocks) is shorter than a gamma cycle (256 clocks), so a request accepted right after an apply is always staged before the next `cycle_start`.
- **Simultaneous events:** an accept and a `cycle_start` on the same edge are independent; the accept does not stage in that edge.

## Structure
- **Shared package `pst_pkg`:**
  - Default THRESHOLD (200) and CYCLE_LEN (256).
  - Channel count.
  - Pair-index phase map constants (AB=0, AC=43, AD=85, BC=128, BD=170, CD=213), shared with the winner mapping and replay controllers.
- **Sub-module `pst_ceil_div`:** sequential 9-bit ÷ 8-bit restoring divider.
  - Ports: start/done; 9 iterations after a load clock.
  - The top level sequences it over the 4 channels and owns the handshake, staging and hold logic.

## Test plan
- **Basic encode:** THRESHOLD=200, phases {10,7,255,0}, en=1111, hold=1 → at the first `cycle_start` ≥ 41 clocks after accept, `cur` = {20,29,1,200}, `applied` pulses, `active=1`. At the next `cycle_start`, all `cur`=0 and `active=0`.
- **Disabled channels:** en=0101, phases {50,50,50,50} → `cur0=4`, `cur1=0`, `cur2=4`, `cur3=0`; `staged_full` set at accept+23.
- **Back-to-back:** request A (hold=3), then B (hold=2) accepted while A is active → A for exactly 3 gamma cycles, B applied on A's expiry `cycle_start` with no zero gap, `applied` pulses twice, B then lasts 2 cycles. `req_ready` stays low while B is staged.
- **Boundary alignment:** `staged_full` is set exactly on a `cycle_start` edge → apply is deferred 256 clocks. A hold=0 request → behaves as hold=1.
- **Reset mid-DIV and mid-hold:** assert `rst` asynchronously → all outputs go to reset values immediately. After release, `req_ready=1` and a new request encodes correctly.
- **Closed loop with the brain:** drive the brain with phases {20,22,120,200} → the brain reports phase0/phase1 ≈ 20/22 (±1) and `winner=0` (AB) after one gamma cycle.
